// File: rtl/pwm_dac_pkg.sv
// rtl/pwm_dac_pkg.sv - state encoding, mid-scale and dither LFSR constants for pwm_dac_out
package pwm_dac_pkg;

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    PLAYING   = 2'd2,
    RAMP_DOWN = 2'd3
  } dac_state_e;

  localparam int MID_SCALE      = 'h800;
  localparam int MID_SCALE_BITS = 12;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int mid_scale_for(input int bits);
    if (bits >= MID_SCALE_BITS) return MID_SCALE << (bits - MID_SCALE_BITS);
    return MID_SCALE >> (MID_SCALE_BITS - bits);
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pwm_dac_out_fifo.sv
// rtl/pwm_dac_out_fifo.sv - sample_fifo: power-of-two sample buffer with flush; pops on empty are ignored
module sample_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q + (AW+1)'(do_push);
    rd_d = rd_q + (AW+1)'(do_pop);
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pwm_dac_out.sv
// rtl/pwm_dac_out.sv - PWM audio DAC with sample FIFO and mute ramps
// Optional PWM_DAC_DITHER_EN adds 2-bit LFSR dither to played samples.
module pwm_dac_out
  import pwm_dac_pkg::*;
#(
  parameter int PWM_BITS   = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int RAMP_STEP  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic                enable,
  input  logic                clear_underflow,
  output logic                pwm_out,
  output logic                sample_tick,
  output logic                underflow
);

  localparam logic [PWM_BITS-1:0] MID     = PWM_BITS'(mid_scale_for(PWM_BITS));
  localparam logic [PWM_BITS-1:0] STEP    = PWM_BITS'(RAMP_STEP);
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  dac_state_e          state_q, state_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                pwm_q, pwm_d;
  logic                tick_q, tick_d;
  logic                uflow_q, uflow_d;
  logic                live_q;

  logic                wrap, pop, uflow_set;
  logic                fifo_push, fifo_full, fifo_empty;
  logic [PWM_BITS-1:0] fifo_head, play_sample;
  logic [PWM_BITS:0]   up_sum;

  assign wrap         = (cnt_q == CNT_MAX);
  // live_q holds ready low until the first edge after reset release
  assign sample_ready = live_q & ~fifo_full;
  assign fifo_push    = sample_valid & sample_ready;
  assign up_sum       = {1'b0, duty_q} + {1'b0, STEP};

  assign pwm_out     = pwm_q;
  assign sample_tick = tick_q;
  assign underflow   = uflow_q;

  sample_fifo #(
    .WIDTH(PWM_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .wdata(sample_in),
    .pop  (pop),
    .flush(state_q == MUTED),
    .rdata(fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

`ifdef PWM_DAC_DITHER_EN
  logic [15:0]       lfsr_q, lfsr_d;
  logic [PWM_BITS:0] dith_sum;

  assign lfsr_d      = wrap ? lfsr_step(lfsr_q) : lfsr_q;
  assign dith_sum    = {1'b0, fifo_head} + (PWM_BITS+1)'(lfsr_q[1:0]);
  assign play_sample = dith_sum[PWM_BITS] ? '1 : dith_sum[PWM_BITS-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= LFSR_SEED;
    else      lfsr_q <= lfsr_d;
  end
`else
  assign play_sample = fifo_head;
`endif

  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    pop       = 1'b0;
    uflow_set = 1'b0;
    cnt_d     = cnt_q + 1'b1;
    tick_d    = wrap;
    if (wrap) begin
      unique case (state_q)
        MUTED: begin
          duty_d = '0;
          if (enable) state_d = RAMP_UP;
        end
        RAMP_UP: begin
          if (!enable) begin
            state_d = RAMP_DOWN;
          end else if (duty_q >= MID) begin
            duty_d  = MID;
            state_d = PLAYING;
          end else begin
            duty_d = (up_sum >= {1'b0, MID}) ? MID : up_sum[PWM_BITS-1:0];
          end
        end
        PLAYING: begin
          if (!enable) begin
            state_d = RAMP_DOWN;
          end else if (!fifo_empty) begin
            pop    = 1'b1;
            duty_d = play_sample;
          end else begin
            uflow_set = 1'b1;
          end
        end
        RAMP_DOWN: begin
          if (enable) begin
            state_d = RAMP_UP;
          end else if (duty_q <= STEP) begin
            duty_d  = '0;
            state_d = MUTED;
          end else begin
            duty_d = duty_q - STEP;
          end
        end
        default: state_d = MUTED;
      endcase
    end
    // A set on the same cycle as a clear wins
    uflow_d = uflow_set | (uflow_q & ~clear_underflow);
    pwm_d   = (cnt_d < duty_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MUTED;
      cnt_q   <= '0;
      duty_q  <= '0;
      pwm_q   <= 1'b0;
      tick_q  <= 1'b0;
      uflow_q <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
      tick_q  <= tick_d;
      uflow_q <= uflow_d;
      live_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pwm_dac_out.sv
// tb/tb_pwm_dac_out.sv - directed bench for pwm_dac_out at 8-bit resolution (256-cycle periods, step 4)
module tb_pwm_dac_out;

  localparam int PB = 8;
  localparam int P  = 1 << PB;

  logic          clk;
  logic          rst;
  logic [PB-1:0] sample_in;
  logic          sample_valid;
  logic          sample_ready;
  logic          enable;
  logic          clear_underflow;
  logic          pwm_out;
  logic          sample_tick;
  logic          underflow;

  int total = 0;
  int bad   = 0;
  int hi;
  int n;

  pwm_dac_out #(
    .PWM_BITS  (PB),
    .FIFO_DEPTH(4),
    .RAMP_STEP (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sample_in      (sample_in),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .enable         (enable),
    .clear_underflow(clear_underflow),
    .pwm_out        (pwm_out),
    .sample_tick    (sample_tick),
    .underflow      (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick();
    int k;
    k = 0;
    while (sample_tick !== 1'b1 && k < 2 * P) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2 * P) check("tick_timeout", 32'(k), 32'(2 * P));
  endtask

  // Counts pwm_out high cycles over one full period starting at the tick cycle
  task automatic measure(output int high);
    high = 0;
    wait_tick();
    for (int i = 0; i < P; i++) begin
      if (pwm_out === 1'b1) high++;
      @(negedge clk);
    end
  endtask

  task automatic push(input logic [PB-1:0] d);
    int k;
    sample_in    = d;
    sample_valid = 1'b1;
    k = 0;
    while (sample_ready !== 1'b1 && k < 2 * P) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2 * P) check("push_timeout", 32'(k), 32'(2 * P));
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; sample_in = '0; sample_valid = 1'b0; enable = 1'b0; clear_underflow = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pwm", pwm_out, 0);
    check("rst_tick", sample_tick, 0);
    check("rst_uflow", underflow, 0);
    check("rst_ready", sample_ready, 0);

    rst = 1'b1;
    enable = 1'b1;
    #1 check("ready_before_edge", sample_ready, 0);
    @(negedge clk);
    check("ready_after_edge", sample_ready, 1);

    for (int k = 0; k <= 32; k++) begin
      measure(hi);
      check($sformatf("ramp_up_%0d", k), hi, 4 * k);
    end
    check("uflow_before_playing", underflow, 0);
    measure(hi);
    check("ramp_hold_mid", hi, 128);
    check("uflow_first_playing", underflow, 1);

    clear_underflow = 1'b1;
    @(negedge clk);
    clear_underflow = 1'b0;
    check("uflow_cleared", underflow, 0);
    repeat (P - 2) @(negedge clk);
    clear_underflow = 1'b1;
    @(negedge clk);
    clear_underflow = 1'b0;
    check("set_clear_tick", sample_tick, 1);
    check("set_beats_clear", underflow, 1);

    push(8'h00); push(8'h40); push(8'hFF);
    measure(hi); check("duty_00", hi, 0);
    measure(hi); check("duty_40", hi, 64);
    measure(hi); check("duty_ff", hi, 255);

    push(8'h10); push(8'h20); push(8'h30); push(8'h40);
    check("full_after_4", sample_ready, 0);
    sample_in = 8'h50;
    sample_valid = 1'b1;
    n = 0;
    while (sample_ready !== 1'b1 && n < 2 * P) begin
      @(negedge clk);
      n++;
    end
    check("fifth_at_boundary", sample_tick, 1);
    check("fifth_waited", 32'(n > P - 8), 1);
    @(negedge clk);
    sample_valid = 1'b0;
    measure(hi); check("duty_20", hi, 32);

    enable = 1'b0;
    push(8'h60); push(8'h70);
    check("full_in_ramp_down", sample_ready, 0);
    for (int k = 0; k <= 12; k++) begin
      measure(hi);
      check($sformatf("ramp_down_%0d", k), hi, 48 - 4 * k);
    end
    check("flushed_when_muted", sample_ready, 1);

    push(8'h11);
    enable = 1'b1;
    measure(hi); check("muted_to_ramp", hi, 0);
    push(8'h21); push(8'h22); push(8'h23);
    check("pwm_high_pre_reset", pwm_out, 1);
    rst = 1'b0;
    #1;
    check("async_rst_pwm", pwm_out, 0);
    check("async_rst_uflow", underflow, 0);
    check("async_rst_ready", sample_ready, 0);
    check("async_rst_tick", sample_tick, 0);
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_rerelease", sample_ready, 1);
    check("uflow_after_rerelease", underflow, 0);

`ifdef PWM_DAC_DITHER_EN
    begin
      logic [15:0] m;
      logic        fb;
      m = 16'hACE1;
      check("lfsr_seed", dut.lfsr_q, m);
      for (int k = 0; k < 4; k++) begin
        wait_tick();
        fb = m[15] ^ m[13] ^ m[12] ^ m[10];
        m  = {m[14:0], fb};
        check($sformatf("lfsr_%0d", k), dut.lfsr_q, m);
        @(negedge clk);
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
